rx_frame_check: RTL and testbench

Downstream consumer of the 5B/4B receive decoder. Collects the decoded byte stream between frame start and the TT end-of-frame pulse, and checks each frame's length and its CRC-16/CCITT. Good frames are stored in a two-bank (ping-pong) byte buffer, so one frame can be received while the host reads the previous one. Bad, aborted and dropped frames are discarded and counted.

---
 rtl/rx_frame_pkg.sv | 34 +++
 rtl/rx_frame_check_crc.sv | 15 +
 rtl/rx_frame_check.sv | 168 ++++++++++++++++
 tb/tb_rx_frame_check.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared definitions for the receive frame checker: CRC constants,
// state encoding and small arithmetic helpers.
package rx_frame_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2,
        DROP  = 2'd3
    } state_t;

    // CRC-16/CCITT-FALSE byte update: MSB first, no reflection.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[15])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Saturating 8-bit increment for the error counters.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_frame_check_crc.sv
// Combinational next-CRC for one byte of the received stream.
module crc16_ccitt_byte
    import rx_frame_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    // Next CRC value after absorbing data_in.
    always_comb begin
        crc_out = crc16_update(crc_in, data_in);
    end

endmodule

// File: rtl/rx_frame_check.sv
// Receive frame checker: collects decoded bytes between frame start and
// the end-of-frame pulse, checks length and CRC, and stores good frames
// in a two-bank buffer that the host drains one frame at a time.
module rx_frame_check #(
    parameter int MAX_LEN = 64,
    parameter int AW      = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rdy,
    input  logic          frame,
    input  logic [7:0]    dataI,
    input  logic          done,
    input  logic          frmAck,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData,
    output logic          frmValid,
    output logic [AW-1:0] frmLen,
    output logic [7:0]    crcErrCnt,
    output logic [7:0]    lenErrCnt,
    output logic [7:0]    abortCnt,
    output logic [7:0]    dropCnt
);

    import rx_frame_pkg::*;

    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
    localparam logic [7:0] LEN_OVF = 8'(MAX_LEN + 1);

    state_t        state;
    logic          frame_d;
    logic [7:0]    byte_cnt;
    logic [15:0]   crc;
    logic [15:0]   crc_next;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    full;
    logic [AW-1:0] len [2];
    logic [7:0]    mem [2*(2**AW)];

    logic          frame_rise;
    logic          frame_fall;
    logic          len_bad;
    logic          commit;
    logic          ack;
    logic          wr_en;
    logic [AW:0]   wr_addr;

    crc16_ccitt_byte u_crc (
        .crc_in  (crc),
        .data_in (dataI),
        .crc_out (crc_next)
    );

    // Frame-edge detection, length/CRC verdict and buffer control strobes.
    always_comb begin
        frame_rise = frame & ~frame_d;
        frame_fall = frame_d & ~frame & ~done;
        len_bad    = (byte_cnt < 8'd3) || (byte_cnt == LEN_OVF);
        commit     = (state == CHECK) && !len_bad && (crc == 16'h0000);
        ack        = frmAck && full[rd_bank];
        wr_en      = (state == RECV) && rdy && (byte_cnt < LEN_MAX);
        wr_addr    = {wr_bank, byte_cnt[AW-1:0]};
    end

    // Registered frame flag. Held high through reset so that a frame still
    // in progress when reset releases is not mistaken for a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_d <= 1'b1;
        else
            frame_d <= frame;
    end

    // Frame state machine with byte counter, CRC and error counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            wr_bank   <= 1'b0;
            len[0]    <= '0;
            len[1]    <= '0;
            crcErrCnt <= '0;
            lenErrCnt <= '0;
            abortCnt  <= '0;
            dropCnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_rise) begin
                        if (full[wr_bank]) begin
                            dropCnt <= sat_inc(dropCnt);
                            state   <= DROP;
                        end else begin
                            byte_cnt <= '0;
                            crc      <= CRC_INIT;
                            state    <= RECV;
                        end
                    end
                end
                RECV: begin
                    // A byte arriving together with done is still absorbed.
                    if (rdy) begin
                        crc <= crc_next;
                        if (byte_cnt != LEN_OVF)
                            byte_cnt <= byte_cnt + 8'd1;
                    end
                    if (done) begin
                        state <= CHECK;
                    end else if (frame_fall) begin
                        abortCnt <= sat_inc(abortCnt);
                        state    <= IDLE;
                    end
                end
                CHECK: begin
                    if (len_bad) begin
                        lenErrCnt <= sat_inc(lenErrCnt);
                    end else if (crc != 16'h0000) begin
                        crcErrCnt <= sat_inc(crcErrCnt);
                    end else begin
                        len[wr_bank] <= AW'(byte_cnt - 8'd2);
                        wr_bank      <= ~wr_bank;
                    end
                    state <= IDLE;
                end
                DROP: begin
                    if (done || frame_fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bank ownership: commits fill the write bank, host acks free the read bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full    <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (commit)
                full[wr_bank] <= 1'b1;
            if (ack) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= dataI;
    end

    // Buffer registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdData <= '0;
        else
            rdData <= mem[{rd_bank, rdAddr}];
    end

    assign frmValid = full[rd_bank];
    assign frmLen   = len[rd_bank];

endmodule

// File: tb/tb_rx_frame_check.sv
// Self-checking bench for rx_frame_check: directed scenarios followed by
// randomized frames, compared against a frame-level reference model.
module tb_rx_frame_check;

    localparam int MAX_LEN = 64;
    localparam int AW      = 7;

    typedef logic [7:0] byte_q_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          rdy;
    logic          frame;
    logic [7:0]    dataI;
    logic          done;
    logic          frmAck;
    logic [AW-1:0] rdAddr;
    logic [7:0]    rdData;
    logic          frmValid;
    logic [AW-1:0] frmLen;
    logic [7:0]    crcErrCnt;
    logic [7:0]    lenErrCnt;
    logic [7:0]    abortCnt;
    logic [7:0]    dropCnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: stored frames as a FIFO of at most two payloads.
    byte_q_t fb_q;
    byte_q_t st_bytes;
    int      st_lens[$];
    int      m_crc, m_len, m_abort, m_drop;

    always #5 clk = ~clk;

    rx_frame_check #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rdy       (rdy),
        .frame     (frame),
        .dataI     (dataI),
        .done      (done),
        .frmAck    (frmAck),
        .rdAddr    (rdAddr),
        .rdData    (rdData),
        .frmValid  (frmValid),
        .frmLen    (frmLen),
        .crcErrCnt (crcErrCnt),
        .lenErrCnt (lenErrCnt),
        .abortCnt  (abortCnt),
        .dropCnt   (dropCnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial CRC-16/CCITT-FALSE over a byte list.
    function automatic logic [15:0] ref_crc(input byte_q_t b);
        logic [15:0] c;
        logic        fbk;
        c = 16'hFFFF;
        foreach (b[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fbk = c[15] ^ b[i][k];
                c   = {c[14:0], 1'b0};
                if (fbk) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        rdy = 1'b0; done = 1'b0; frmAck = 1'b0;
    endtask

    task automatic build_good(input int plen);
        logic [15:0] c;
        fb_q.delete();
        for (int i = 0; i < plen; i++) fb_q.push_back(8'($urandom));
        c = ref_crc(fb_q);
        fb_q.push_back(c[15:8]);
        fb_q.push_back(c[7:0]);
    endtask

    task automatic build_random(input int n);
        fb_q.delete();
        for (int i = 0; i < n; i++) fb_q.push_back(8'($urandom));
    endtask

    // Frame-level outcome of the frame currently in fb_q.
    task automatic model_frame(input bit abort_it);
        int n;
        n = fb_q.size();
        if (st_lens.size() == 2) m_drop = sat(m_drop + 1);
        else if (abort_it) m_abort = sat(m_abort + 1);
        else if (n < 3 || n > MAX_LEN) m_len = sat(m_len + 1);
        else if (ref_crc(fb_q) != 16'h0000) m_crc = sat(m_crc + 1);
        else begin
            for (int i = 0; i < n - 2; i++) st_bytes.push_back(fb_q[i]);
            st_lens.push_back(n - 2);
        end
    endtask

    task automatic send_body(input bit merge);
        frame = 1'b1; tick;
        foreach (fb_q[i]) begin
            if ($urandom_range(0, 3) == 0) tick;
            if (merge && i == fb_q.size() - 1) begin frame = 1'b0; done = 1'b1; end
            rdy = 1'b1; dataI = fb_q[i]; tick;
        end
    endtask

    task automatic send_frame(input bit abort_it, input bit merge);
        bit merged;
        merged = merge && !abort_it && (fb_q.size() > 0);
        send_body(merged);
        if (!merged) begin frame = 1'b0; done = !abort_it; tick; end
        tick; tick;
        model_frame(abort_it);
    endtask

    task automatic check_state();
        check_eq("frmValid", frmValid, (st_lens.size() != 0) ? 1 : 0);
        if (st_lens.size() != 0) check_eq("frmLen", frmLen, st_lens[0]);
        check_eq("crcErrCnt", crcErrCnt, m_crc);
        check_eq("lenErrCnt", lenErrCnt, m_len);
        check_eq("abortCnt", abortCnt, m_abort);
        check_eq("dropCnt", dropCnt, m_drop);
    endtask

    task automatic read_head(input int nreads);
        int a;
        if (st_lens.size() == 0) return;
        for (int i = 0; i < nreads; i++) begin
            if (i == 0) a = 0;
            else if (i == 1) a = st_lens[0] - 1;
            else a = $urandom_range(0, st_lens[0] - 1);
            rdAddr = AW'(a); tick;
            check_eq("rdData", rdData, st_bytes[a]);
        end
    endtask

    task automatic do_ack();
        int n;
        frmAck = 1'b1; tick;
        if (st_lens.size() > 0) begin
            n = st_lens.pop_front();
            repeat (n) void'(st_bytes.pop_front());
        end
        check_state();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdData"}, rdData, 0);
        check_eq({tag, "_frmValid"}, frmValid, 0);
        check_eq({tag, "_frmLen"}, frmLen, 0);
        check_eq({tag, "_crcErr"}, crcErrCnt, 0);
        check_eq({tag, "_lenErr"}, lenErrCnt, 0);
        check_eq({tag, "_abort"}, abortCnt, 0);
        check_eq({tag, "_drop"}, dropCnt, 0);
    endtask

    initial begin
        #1_500_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, plen, l1, l2;
        reset = 1'b1; rdy = 1'b0; frame = 1'b0; done = 1'b0;
        frmAck = 1'b0; dataI = '0; rdAddr = '0;
        m_crc = 0; m_len = 0; m_abort = 0; m_drop = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        tick; tick;
        check_state();

        // Known-answer frame "123456789" + 0x29B1; frmValid rises at D+2.
        fb_q.delete();
        for (int i = 0; i < 9; i++) fb_q.push_back(8'(8'h31 + i));
        fb_q.push_back(8'h29); fb_q.push_back(8'hB1);
        send_body(1'b0);
        frame = 1'b0; done = 1'b1; tick;
        check_eq("valid_d1", frmValid, 0);
        tick;
        check_eq("valid_d2", frmValid, 1);
        check_eq("len_d2", frmLen, 9);
        tick;
        model_frame(1'b0);
        check_state();
        rdAddr = 0; tick; check_eq("kat_byte0", rdData, 8'h31);
        rdAddr = 8; tick; check_eq("kat_byte8", rdData, 8'h39);
        do_ack();

        // Same frame with corrupted last CRC byte.
        fb_q[10] = 8'hB0;
        send_frame(1'b0, 1'b0);
        check_eq("kat_crcerr", crcErrCnt, 1);
        check_state();

        // Abort after four bytes, then a good frame.
        build_random(4);
        send_frame(1'b1, 1'b0);
        check_eq("abort_once", abortCnt, 1);
        build_good(5); send_frame(1'b0, 1'b1);
        check_state(); read_head(3);
        do_ack();

        // Three good frames without ack: third is dropped.
        l1 = $urandom_range(1, 20); build_good(l1); send_frame(1'b0, 1'b0);
        l2 = $urandom_range(1, 20); build_good(l2); send_frame(1'b0, 1'b1);
        build_good(7); send_frame(1'b0, 1'b0);
        check_eq("b2b_drop", dropCnt, 1);
        check_eq("b2b_len1", frmLen, l1);
        check_state(); read_head(2);
        do_ack();
        check_eq("b2b_len2", frmLen, l2);
        read_head(3);
        build_good(MAX_LEN - 2); send_frame(1'b0, 1'b0);
        check_state();
        do_ack(); read_head(4);
        do_ack();

        // Length boundaries: MAX_LEN+1 bytes and 2 bytes.
        build_random(MAX_LEN + 1); send_frame(1'b0, 1'b0);
        build_random(2); send_frame(1'b0, 1'b1);
        check_eq("len_errs", lenErrCnt, 2);
        check_state();

        // Randomized frames with random host activity.
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                plen = ($urandom_range(0, 4) == 0) ? MAX_LEN - 2 : $urandom_range(1, 24);
                build_good(plen);
            end else if (kind == 6) begin
                build_good($urandom_range(1, 24));
                plen = $urandom_range(0, fb_q.size() - 1);
                fb_q[plen] = fb_q[plen] ^ (8'h01 << $urandom_range(0, 7));
            end else if (kind == 7) begin
                build_random($urandom_range(0, 2));
            end else if (kind == 8) begin
                build_random($urandom_range(MAX_LEN + 1, MAX_LEN + 3));
            end else begin
                build_random($urandom_range(0, 10));
            end
            send_frame(kind == 9, $urandom_range(0, 1) == 1);
            check_state();
            if ($urandom_range(0, 1) == 1) read_head(3);
            if ($urandom_range(0, 9) < 4) do_ack();
        end

        // Length-error counter saturation.
        while (st_lens.size() > 0) do_ack();
        for (int f = 0; f < 260; f++) begin
            fb_q.delete();
            send_frame(1'b0, 1'b0);
        end
        check_eq("len_sat", lenErrCnt, 8'hFF);
        check_state();

        // Reset during the 5th byte of a frame.
        build_good(3); send_frame(1'b0, 1'b0);
        check_state();
        build_good(6);
        frame = 1'b1; tick;
        for (int i = 0; i < 4; i++) begin rdy = 1'b1; dataI = fb_q[i]; tick; end
        rdy = 1'b1; dataI = fb_q[4];
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b0; rdy = 1'b0;
        st_bytes.delete(); st_lens.delete();
        m_crc = 0; m_len = 0; m_abort = 0; m_drop = 0;
        for (int i = 5; i < 8; i++) begin rdy = 1'b1; dataI = fb_q[i]; tick; end
        frame = 1'b0; done = 1'b1; tick;
        tick; tick;
        check_state();
        build_good(11); send_frame(1'b0, 1'b0);
        check_eq("post_rst_valid", frmValid, 1);
        check_state(); read_head(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
